n_bin_frame_avg: RTL and testbench

//  Successor to the fixed-config bin averager. Accepts BINS unsigned FFT bins/beat, FRAME_LEN beats/frame.

---
 rtl/n_bin_frame_avg.sv | 130 +++++++++++++
 tb/tb_n_bin_frame_avg.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/n_bin_frame_avg.sv
`timescale 1ns/1ps
// Block averager: sums 2^k consecutive frames per beat position and streams the
// rounded or truncated mean of each bin during the block's final frame.
module n_bin_frame_avg #(
   parameter int unsigned N              = 16,
   parameter int unsigned BINS           = 4,
   parameter int unsigned FRAME_LEN      = 64,
   parameter int unsigned MAX_AVGS_LOG2  = 7,
   parameter int unsigned ROUND          = 1,
   localparam int unsigned AVG_W         = $clog2(MAX_AVGS_LOG2 + 1)
) (
   input  logic                   clk,
   input  logic                   arest_n,
   input  logic                   in_valid,
   input  logic                   in_last,
   input  logic [BINS-1:0][N-1:0] in_data,
   input  logic [AVG_W-1:0]       n_avgs_log2,
   output logic                   out_valid,
   output logic                   out_last,
   output logic [BINS-1:0][N-1:0] out_data,
   output logic                   avg_done,
   output logic                   frame_err
);

   localparam int unsigned SW = N + MAX_AVGS_LOG2 + ((ROUND != 0) ? 1 : 0);
   localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned FW = MAX_AVGS_LOG2 + 1;

   typedef enum logic {
      S_ACCUM,
      S_SYNC
   } state_t;

   state_t                  r_state, w_state_nxt;
   logic [BW-1:0]           r_beat_cnt, w_beat_nxt;
   logic [FW-1:0]           r_frame_cnt, w_frame_nxt;
   logic [AVG_W-1:0]        r_k_l, w_k_in, w_k;
   logic                    w_accept, w_block_start, w_end_beat, w_err, w_final, w_emit;
   logic [SW:0]             w_rnd;
   logic [BINS-1:0][SW-1:0] w_acc_nxt;
   logic [BINS-1:0][SW:0]   w_sum, w_shift;
   logic [BINS-1:0][N-1:0]  w_avg;
   logic [BINS-1:0][SW-1:0] r_acc [FRAME_LEN];

   // k only takes effect at a block boundary; otherwise the latched value rules.
   always_comb begin
      w_k_in        = (n_avgs_log2 > AVG_W'(MAX_AVGS_LOG2)) ? AVG_W'(MAX_AVGS_LOG2) : n_avgs_log2;
      w_block_start = (r_beat_cnt == '0) && (r_frame_cnt == '0);
      w_k           = w_block_start ? w_k_in : r_k_l;
      w_end_beat    = (r_beat_cnt == BW'(FRAME_LEN - 1));
      w_err         = (in_last != w_end_beat);
      w_final       = (r_frame_cnt == ((FW'(1) << w_k) - FW'(1)));
      w_accept      = in_valid && (r_state == S_ACCUM);
      w_emit        = w_accept && !w_err && w_final;
      w_rnd         = ((ROUND != 0) && (w_k != '0)) ? ((SW+1)'(1) << (w_k - AVG_W'(1))) : '0;
   end

   always_comb begin
      w_acc_nxt = '0;
      w_sum     = '0;
      w_shift   = '0;
      w_avg     = '0;
      for (int unsigned l = 0; l < BINS; l++) begin
         w_acc_nxt[l] = ((r_frame_cnt == '0) ? '0 : r_acc[r_beat_cnt][l]) + SW'(in_data[l]);
         w_sum[l]     = {1'b0, w_acc_nxt[l]} + w_rnd;
         w_shift[l]   = w_sum[l] >> w_k;
         w_avg[l]     = (|w_shift[l][SW:N]) ? '1 : w_shift[l][N-1:0];
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_beat_nxt  = r_beat_cnt;
      w_frame_nxt = r_frame_cnt;
      if (in_valid) begin
         case (r_state)
            S_ACCUM: begin
               if (w_err) begin
                  w_beat_nxt  = '0;
                  w_frame_nxt = '0;
                  w_state_nxt = in_last ? S_ACCUM : S_SYNC;
               end else if (w_end_beat) begin
                  w_beat_nxt  = '0;
                  w_frame_nxt = w_final ? '0 : r_frame_cnt + FW'(1);
               end else begin
                  w_beat_nxt  = r_beat_cnt + BW'(1);
               end
            end
            S_SYNC: begin
               if (in_last) begin
                  w_state_nxt = S_ACCUM;
                  w_beat_nxt  = '0;
                  w_frame_nxt = '0;
               end
            end
            default: w_state_nxt = S_SYNC;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!arest_n) begin
         r_state     <= S_ACCUM;
         r_beat_cnt  <= '0;
         r_frame_cnt <= '0;
         r_k_l       <= '0;
         out_valid   <= 1'b0;
         out_last    <= 1'b0;
         out_data    <= '0;
         avg_done    <= 1'b0;
         frame_err   <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_beat_cnt  <= w_beat_nxt;
         r_frame_cnt <= w_frame_nxt;
         if (w_accept && w_block_start) r_k_l <= w_k_in;
         out_valid   <= w_emit;
         out_last    <= w_emit && in_last;
         avg_done    <= w_emit && in_last;
         frame_err   <= w_accept && w_err;
         if (w_emit) out_data <= w_avg;
      end
   end

   // Sums need no reset: frame 0 of every block overwrites rather than adds.
   always_ff @(posedge clk) begin
      if (w_accept && !w_err) r_acc[r_beat_cnt] <= w_acc_nxt;
   end

endmodule

// File: tb/tb_n_bin_frame_avg.sv
`timescale 1ns/1ps
// Bench for n_bin_frame_avg: ROUND=1 and ROUND=0 instances share one stimulus
// stream; a frame-store model recomputes every averaged beat from raw frames.
module tb_n_bin_frame_avg;
   localparam int unsigned N     = 16;
   localparam int unsigned BINS  = 4;
   localparam int unsigned FL    = 4;
   localparam int unsigned MAXK  = 7;
   localparam int unsigned AVG_W = 3;

   logic                   clk = 1'b0;
   logic                   arest_n, in_valid, in_last;
   logic [BINS-1:0][N-1:0] in_data;
   logic [AVG_W-1:0]       n_avgs_log2;
   logic                   r_valid, r_last, r_done, r_err;
   logic                   t_valid, t_last, t_done, t_err;
   logic [BINS-1:0][N-1:0] r_data, t_data;

   n_bin_frame_avg #(.N(N), .BINS(BINS), .FRAME_LEN(FL), .MAX_AVGS_LOG2(MAXK), .ROUND(1)) u_dut_rnd (
      .clk(clk), .arest_n(arest_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .n_avgs_log2(n_avgs_log2), .out_valid(r_valid), .out_last(r_last), .out_data(r_data),
      .avg_done(r_done), .frame_err(r_err));

   n_bin_frame_avg #(.N(N), .BINS(BINS), .FRAME_LEN(FL), .MAX_AVGS_LOG2(MAXK), .ROUND(0)) u_dut_trc (
      .clk(clk), .arest_n(arest_n), .in_valid(in_valid), .in_last(in_last), .in_data(in_data),
      .n_avgs_log2(n_avgs_log2), .out_valid(t_valid), .out_last(t_last), .out_data(t_data),
      .avg_done(t_done), .frame_err(t_err));

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int obs_valid = 0, obs_done = 0, obs_err = 0;
   logic [63:0] last_r = '0, last_t = '0;

   // Reference model: stores every frame of the current block, averages at the final frame.
   bit                     m_init = 1'b0;
   bit                     m_sync;
   int                     m_beat, m_frame, m_k, m_sum;
   logic [BINS-1:0][N-1:0] blk [128][FL];
   logic                   e_valid, e_last, e_done, e_err;
   logic [BINS-1:0][N-1:0] e_data_r, e_data_t;

   function automatic logic [N-1:0] sat(input int v);
      return (v > 65535) ? 16'hFFFF : v[15:0];
   endfunction

   always @(posedge clk) begin
      e_valid = 1'b0; e_last = 1'b0; e_done = 1'b0; e_err = 1'b0;
      if (!arest_n) begin
         m_init = 1'b1; m_sync = 1'b0; m_beat = 0; m_frame = 0;
         e_data_r = '0; e_data_t = '0;
      end else if (m_init && in_valid) begin
         if (m_sync) begin
            if (in_last) m_sync = 1'b0;
         end else begin
            if (m_beat == 0 && m_frame == 0)
               m_k = (int'(n_avgs_log2) > MAXK) ? MAXK : int'(n_avgs_log2);
            if (in_last != (m_beat == FL - 1)) begin
               e_err = 1'b1; m_sync = !in_last; m_beat = 0; m_frame = 0;
            end else begin
               blk[m_frame][m_beat] = in_data;
               if (m_frame == (1 << m_k) - 1) begin
                  e_valid = 1'b1; e_last = in_last; e_done = in_last;
                  for (int i = 0; i < BINS; i++) begin
                     m_sum = 0;
                     for (int f = 0; f <= m_frame; f++) m_sum += int'(blk[f][m_beat][i]);
                     e_data_t[i] = sat(m_sum >> m_k);
                     e_data_r[i] = sat((m_sum + ((m_k > 0) ? (1 << (m_k - 1)) : 0)) >> m_k);
                  end
               end
               if (in_last) begin
                  m_beat  = 0;
                  m_frame = (m_frame == (1 << m_k) - 1) ? 0 : m_frame + 1;
               end else begin
                  m_beat++;
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic compare();
      if (!m_init) return;
      check("rnd_flags", 64'({r_valid, r_last, r_done, r_err}), 64'({e_valid, e_last, e_done, e_err}));
      check("trc_flags", 64'({t_valid, t_last, t_done, t_err}), 64'({e_valid, e_last, e_done, e_err}));
      if (e_valid) begin
         check("rnd_data", r_data, e_data_r);
         check("trc_data", t_data, e_data_t);
      end
      if (r_valid) begin obs_valid++; last_r = r_data; end
      if (t_valid) last_t = t_data;
      if (r_done) obs_done++;
      if (r_err)  obs_err++;
   endtask

   task automatic step();
      @(negedge clk);
      compare();
   endtask

   task automatic beat(input logic v, input logic l, input logic [63:0] d);
      in_valid = v; in_last = l; in_data = d;
      step();
   endtask

   task automatic gaps(input int pct);
      while (int'($urandom_range(99, 0)) < pct) beat(1'b0, 1'($urandom), {$urandom, $urandom});
   endtask

   function automatic logic [63:0] mk(input int mode, input int val, input int b);
      logic [BINS-1:0][N-1:0] d;
      for (int i = 0; i < BINS; i++) begin
         case (mode)
            0:       d[i] = 16'($urandom);
            1:       d[i] = 16'(b * 4 + i);
            default: d[i] = 16'(val);
         endcase
      end
      return d;
   endfunction

   task automatic frame(input int mode, input int val, input int pct);
      for (int b = 0; b < FL; b++) begin
         gaps(pct);
         beat(1'b1, (b == FL - 1), mk(mode, val, b));
      end
   endtask

   int bv, bd, be;

   task automatic mark();
      bv = obs_valid; bd = obs_done; be = obs_err;
   endtask

   task automatic check_reset(input string name);
      check(name, 64'({r_valid, r_last, r_done, r_err, t_valid, t_last, t_done, t_err}), 64'h0);
      check({name, "_data"}, r_data | t_data, 64'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      arest_n = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; n_avgs_log2 = '0;
      step(); step();
      check_reset("reset_state");
      arest_n = 1'b1;

      // k=0 bypass with ramp data
      n_avgs_log2 = 3'd0; mark();
      repeat (3) frame(1, 0, 0);
      check("t1_beats", 64'(obs_valid - bv), 64'd12);
      check("t1_done", 64'(obs_done - bd), 64'd3);
      check("t1_data", last_r, 64'h000f_000e_000d_000c);

      // k=2, frames of 10,11,12,13
      n_avgs_log2 = 3'd2; mark();
      for (int f = 0; f < 4; f++) frame(2, 10 + f, 20);
      check("t2_beats", 64'(obs_valid - bv), 64'd4);
      check("t2_round", last_r, 64'h000c_000c_000c_000c);
      check("t2_trunc", last_t, 64'h000b_000b_000b_000b);

      // k=7, all-max data
      n_avgs_log2 = 3'd7; mark();
      repeat (127) frame(2, 65535, 0);
      check("t3_early", 64'(obs_valid - bv), 64'd0);
      frame(2, 65535, 0);
      check("t3_beats", 64'(obs_valid - bv), 64'd4);
      check("t3_done", 64'(obs_done - bd), 64'd1);
      check("t3_round", last_r, 64'hffff_ffff_ffff_ffff);
      check("t3_trunc", last_t, 64'hffff_ffff_ffff_ffff);

      // early in_last inside the first frame of a k=1 block
      n_avgs_log2 = 3'd1; mark();
      beat(1'b1, 1'b0, mk(0, 0, 0));
      beat(1'b1, 1'b0, mk(0, 0, 1));
      beat(1'b1, 1'b1, mk(0, 0, 2));
      check("t4_err", 64'(obs_err - be), 64'd1);
      check("t4_noout", 64'(obs_valid - bv), 64'd0);
      frame(0, 0, 10); frame(0, 0, 10);
      check("t4_beats", 64'(obs_valid - bv), 64'd4);
      // missing in_last: resync needed
      mark();
      for (int b = 0; b < FL; b++) beat(1'b1, 1'b0, mk(0, 0, b));
      beat(1'b1, 1'b0, mk(0, 0, 0));
      beat(1'b1, 1'b0, mk(0, 0, 0));
      beat(1'b1, 1'b1, mk(0, 0, 0));
      check("t4_sync_err", 64'(obs_err - be), 64'd1);
      check("t4_sync_noout", 64'(obs_valid - bv), 64'd0);
      frame(0, 0, 10); frame(0, 0, 10);
      check("t4_sync_beats", 64'(obs_valid - bv), 64'd4);

      // k change mid-block with gaps
      n_avgs_log2 = 3'd1; mark();
      frame(0, 0, 30);
      n_avgs_log2 = 3'd3;
      frame(0, 0, 30);
      check("t5_k1_beats", 64'(obs_valid - bv), 64'd4);
      check("t5_k1_done", 64'(obs_done - bd), 64'd1);
      mark();
      repeat (7) frame(0, 0, 30);
      check("t5_k3_early", 64'(obs_valid - bv), 64'd0);
      frame(0, 0, 30);
      check("t5_k3_beats", 64'(obs_valid - bv), 64'd4);

      // reset mid-block
      n_avgs_log2 = 3'd1;
      frame(0, 0, 0);
      beat(1'b1, 1'b0, mk(0, 0, 0));
      beat(1'b1, 1'b0, mk(0, 0, 1));
      arest_n = 1'b0;
      beat(1'b1, 1'b0, mk(0, 0, 2));
      check_reset("t6_reset");
      arest_n = 1'b1; mark();
      frame(0, 0, 0);
      check("t6_noout", 64'(obs_valid - bv), 64'd0);
      frame(0, 0, 0);
      check("t6_beats", 64'(obs_valid - bv), 64'd4);
      check("t6_done", 64'(obs_done - bd), 64'd1);

      // random k, gaps and framing errors
      for (int fr = 0; fr < 60; fr++) begin
         n_avgs_log2 = 3'($urandom_range(2, 0));
         for (int b = 0; b < FL; b++) begin
            logic l;
            gaps(25);
            l = (b == FL - 1);
            if ($urandom_range(99, 0) < 4) l = !l;
            beat(1'b1, l, mk(0, 0, b));
         end
      end

      beat(1'b0, 1'b0, '0);
      beat(1'b0, 1'b0, '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
